// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: N-tap delay line, one signed MAC per cycle, scaled result.
// Optional output clamping on accumulator overflow is enabled by defining FIR_SAT_EN.
module fir_mac_sequencer #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(N)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         valid,
    input  logic signed [DATA_WIDTH-1:0] sample,
    input  logic                         clear_i,
    input  logic [3:0]                   bus_addr_i,
    output logic [3:0]                   coeff_addr_o,
    input  logic signed [DATA_WIDTH-1:0] coeff_data_i,
    output logic [DATA_WIDTH-1:0]        result,
    output logic                         result_valid,
    output logic                         busy_o,
    output logic                         overrun_o,
    output logic                         sat_o
);

    localparam int CNT_W  = $clog2(N + 1);
    localparam int PROD_W = 2*DATA_WIDTH;
    localparam int TOP    = 2*DATA_WIDTH - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                         state_reg;
    logic [CNT_W-1:0]               cnt_reg;
    logic signed [ACC_WIDTH-1:0]    acc_reg;
    logic [DATA_WIDTH-1:0]          result_reg;
    logic                           result_valid_reg;
    logic                           busy_reg;
    logic                           overrun_reg;
    logic                           sat_reg;

    logic                           accept;
    logic signed [DATA_WIDTH-1:0]   tap_in [N];
    logic signed [DATA_WIDTH-1:0]   tap_q  [N];
    logic signed [DATA_WIDTH-1:0]   x_sel;
    logic signed [PROD_W-1:0]       prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic [DATA_WIDTH-1:0]          scaled;
    logic [DATA_WIDTH-1:0]          result_next;
    logic                           sat_next;
    logic [ACC_WIDTH-TOP-1:0]       acc_top;
    logic                           unused_acc_lsb;

    // Delay line only moves on an accepted sample; clear and reset flush it.
    assign accept = (state_reg == IDLE) && valid && !clear_i;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_tap
            logic signed [DATA_WIDTH-1:0] tap_reg;

            always_ff @(posedge clk_i) begin
                if (rst_i || clear_i) begin
                    tap_reg <= '0;
                end else if (accept) begin
                    tap_reg <= tap_in[gi];
                end
            end

            assign tap_q[gi] = tap_reg;

            if (gi == 0) begin : g_head
                assign tap_in[gi] = sample;
            end else begin : g_link
                assign tap_in[gi] = tap_q[gi-1];
            end
        end
    endgenerate

    // RAM data arriving while cnt==k belongs to tap k-1 (one-cycle read latency).
    always_comb begin
        x_sel = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt_reg == CNT_W'(k + 1)) begin
                x_sel = tap_q[k];
            end
        end
    end

    assign prod     = coeff_data_i * x_sel;
    assign prod_ext = {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};

    assign coeff_addr_o = ((state_reg == RUN) && (cnt_reg < CNT_W'(N)))
                          ? 4'(cnt_reg) : bus_addr_i;

    assign scaled         = acc_reg[TOP:DATA_WIDTH-1];
    assign acc_top        = acc_reg[ACC_WIDTH-1:TOP];
    assign unused_acc_lsb = ^acc_reg[DATA_WIDTH-2:0];

`ifdef FIR_SAT_EN
    logic acc_ovf;

    // In range only when every bit above the result MSB matches it.
    assign acc_ovf = !((&acc_top) || !(|acc_top));

    always_comb begin
        result_next = scaled;
        sat_next    = 1'b0;
        if (acc_ovf) begin
            sat_next    = 1'b1;
            result_next = acc_reg[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                               : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end
`else
    logic unused_acc_top;

    assign unused_acc_top = ^acc_top[ACC_WIDTH-TOP-1:1];

    always_comb begin
        result_next = scaled;
        sat_next    = 1'b0;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            acc_reg          <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
            overrun_reg      <= 1'b0;
            sat_reg          <= 1'b0;
        end else begin
            result_valid_reg <= 1'b0;
            overrun_reg      <= 1'b0;
            sat_reg          <= 1'b0;
            if (clear_i) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
                acc_reg   <= '0;
                busy_reg  <= 1'b0;
            end else begin
                overrun_reg <= valid && (state_reg != IDLE);
                case (state_reg)
                    IDLE: begin
                        if (valid) begin
                            acc_reg   <= '0;
                            cnt_reg   <= '0;
                            state_reg <= RUN;
                            busy_reg  <= 1'b1;
                        end
                    end
                    RUN: begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg != '0) begin
                            acc_reg <= acc_reg + prod_ext;
                        end
                        if (cnt_reg == CNT_W'(N)) begin
                            state_reg <= DONE;
                        end
                    end
                    DONE: begin
                        result_reg       <= result_next;
                        result_valid_reg <= 1'b1;
                        sat_reg          <= sat_next;
                        state_reg        <= IDLE;
                        busy_reg         <= 1'b0;
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign busy_o       = busy_reg;
    assign overrun_o    = overrun_reg;
    assign sat_o        = sat_reg;

endmodule
